// File: rtl/memory_reader.sv
// Serialises a 16x1 memory snapshot bit by bit over a valid/ready link,
// starting at a programmable cell and running for a programmable length.
module memory_reader #(
    parameter int WRAP = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  start_addr,
    input  logic [3:0]  length,
    input  logic [15:0] mem,
    output logic [3:0]  sl,
    output logic        dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic        done,
    output logic        truncated,
    output logic        parity,
    output logic [4:0]  sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_r;
    logic [15:0] snapshot_r;
    logic [4:0]  remaining_r;

    logic        accept_s;
    logic        last_s;
    logic        trunc_s;
    logic [3:0]  sl_next_s;

    function automatic logic parity_update(input logic acc, input logic bit_in);
        return acc ^ bit_in;
    endfunction

    // A length field of zero stands for a full 16-bit sweep.
    function automatic logic [4:0] decode_length(input logic [3:0] len);
        return (len == 4'd0) ? 5'd16 : {1'b0, len};
    endfunction

    // Accept qualification and end-of-transfer conditions for the current bit.
    always_comb begin
        accept_s  = (state_r == SEND) && dout_valid && dout_ready;
        last_s    = (remaining_r == 5'd1);
        trunc_s   = (WRAP == 0) && (sl == 4'd15) && !last_s;
        sl_next_s = sl + 4'd1;
    end

    // Transfer FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            snapshot_r  <= 16'h0000;
            remaining_r <= 5'd0;
            sl          <= 4'd0;
            dout        <= 1'b0;
            dout_valid  <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            truncated   <= 1'b0;
            parity      <= 1'b0;
            sent        <= 5'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        sl          <= start_addr;
                        remaining_r <= decode_length(length);
                        sent        <= 5'd0;
                        parity      <= 1'b0;
                        truncated   <= 1'b0;
                        busy        <= 1'b1;
                        state_r     <= LOAD;
                    end
                end
                LOAD: begin
                    snapshot_r <= mem;
                    dout       <= mem[sl];
                    dout_valid <= 1'b1;
                    state_r    <= SEND;
                end
                SEND: begin
                    if (accept_s) begin
                        sl          <= sl_next_s;
                        remaining_r <= remaining_r - 5'd1;
                        sent        <= sent + 5'd1;
                        parity      <= parity_update(parity, dout);
                        dout        <= snapshot_r[sl_next_s];
                        if (last_s || trunc_s) begin
                            dout_valid <= 1'b0;
                            done       <= 1'b1;
                            truncated  <= trunc_s;
                            state_r    <= DONE;
                        end
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    dout_valid <= 1'b0;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_reader.sv
// Directed bench for memory_reader: one wrapping and one non-wrapping
// instance share all inputs; expectations are hand-computed constants.
module tb_memory_reader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  start_addr;
    logic [3:0]  length;
    logic [15:0] mem;
    logic        dout_ready;

    logic [3:0]  w_sl, n_sl;
    logic        w_dout, n_dout;
    logic        w_valid, n_valid;
    logic        w_busy, n_busy;
    logic        w_done, n_done;
    logic        w_trunc, n_trunc;
    logic        w_parity, n_parity;
    logic [4:0]  w_sent, n_sent;

    int n_vectors;
    int n_miscompares;

    memory_reader #(.WRAP(1)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .length(length), .mem(mem), .sl(w_sl), .dout(w_dout),
        .dout_valid(w_valid), .dout_ready(dout_ready), .busy(w_busy),
        .done(w_done), .truncated(w_trunc), .parity(w_parity), .sent(w_sent)
    );

    memory_reader #(.WRAP(0)) u_nowrap (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .length(length), .mem(mem), .sl(n_sl), .dout(n_dout),
        .dout_valid(n_valid), .dout_ready(dout_ready), .busy(n_busy),
        .done(n_done), .truncated(n_trunc), .parity(n_parity), .sent(n_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic start_transfer(input logic [3:0] addr, input logic [3:0] len, input logic [15:0] data);
        start_addr = addr;
        length     = len;
        mem        = data;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (w_busy || n_busy); i++) @(negedge clk);
        check_value("idle_timeout", {30'd0, w_busy, n_busy}, 32'd0);
    endtask

    logic [15:0] captured;
    logic [15:0] bp_data;
    int          nbits;
    logic        stall_prev;
    logic        dout_prev;
    logic [3:0]  sl_prev;
    logic        ready_new;
    logic        seen_done;

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        rst        = 1'b0;
        start      = 1'b0;
        start_addr = 4'd0;
        length     = 4'd0;
        mem        = 16'h0000;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check_value("rst_busy",   {31'd0, w_busy},  32'd0);
        check_value("rst_valid",  {31'd0, w_valid}, 32'd0);
        check_value("rst_done",   {31'd0, w_done},  32'd0);
        check_value("rst_sl",     {28'd0, w_sl},    32'd0);
        check_value("rst_sent",   {27'd0, w_sent},  32'd0);
        check_value("rst_parity", {31'd0, w_parity}, 32'd0);
        check_value("rst_trunc",  {31'd0, n_trunc}, 32'd0);
        check_value("rst_dout",   {31'd0, w_dout},  32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Basic 4-bit read of A5C3 from cell 0: bits 1,1,0,0
        start_transfer(4'd0, 4'd4, 16'hA5C3);
        check_value("t1_load_busy",  {31'd0, w_busy},  32'd1);
        check_value("t1_load_valid", {31'd0, w_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_bits;
            exp_bits = 4'b0011;
            @(negedge clk);
            check_value("t1_valid", {31'd0, w_valid}, 32'd1);
            check_value("t1_sl",    {28'd0, w_sl},    i);
            check_value("t1_dout",  {31'd0, w_dout},  {31'd0, exp_bits[i]});
            check_value("t1_done_early", {31'd0, w_done}, 32'd0);
        end
        @(negedge clk);
        check_value("t1_done",   {31'd0, w_done},   32'd1);
        check_value("t1_dvalid", {31'd0, w_valid},  32'd0);
        check_value("t1_parity", {31'd0, w_parity}, 32'd0);
        check_value("t1_sent",   {27'd0, w_sent},   32'd4);
        @(negedge clk);
        check_value("t1_done_pulse", {31'd0, w_done}, 32'd0);
        check_value("t1_idle",       {31'd0, w_busy}, 32'd0);
        check_value("t1_sent_hold",  {27'd0, w_sent}, 32'd4);

        // Back-to-back wrap read of 8001 from cell 14
        start_transfer(4'd14, 4'd4, 16'h8001);
        check_value("t2_b2b_busy", {31'd0, w_busy}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic [3:0] exp_bits;
            logic [3:0] exp_sl [4];
            exp_bits = 4'b0110;
            exp_sl[0] = 4'd14; exp_sl[1] = 4'd15; exp_sl[2] = 4'd0; exp_sl[3] = 4'd1;
            @(negedge clk);
            check_value("t2_sl",   {28'd0, w_sl},   {28'd0, exp_sl[i]});
            check_value("t2_dout", {31'd0, w_dout}, {31'd0, exp_bits[i]});
        end
        @(negedge clk);
        check_value("t2_done",    {31'd0, w_done},   32'd1);
        check_value("t2_trunc",   {31'd0, w_trunc},  32'd0);
        check_value("t2_sent",    {27'd0, w_sent},   32'd4);
        check_value("t2_nw_trunc",  {31'd0, n_trunc},  32'd1);
        check_value("t2_nw_sent",   {27'd0, n_sent},   32'd2);
        check_value("t2_nw_parity", {31'd0, n_parity}, 32'd1);
        check_value("t2_nw_busy",   {31'd0, n_busy},   32'd0);
        wait_idle();

        // Truncation on the non-wrapping instance: FFFF from cell 13, length 16
        start_transfer(4'd13, 4'd0, 16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("t3_sl",   {28'd0, n_sl},   13 + i);
            check_value("t3_dout", {31'd0, n_dout}, 32'd1);
        end
        @(negedge clk);
        check_value("t3_done",   {31'd0, n_done},   32'd1);
        check_value("t3_trunc",  {31'd0, n_trunc},  32'd1);
        check_value("t3_sent",   {27'd0, n_sent},   32'd3);
        check_value("t3_parity", {31'd0, n_parity}, 32'd1);
        wait_idle();
        check_value("t3_w_sent",  {27'd0, w_sent},  32'd16);
        check_value("t3_w_trunc", {31'd0, w_trunc}, 32'd0);

        // Backpressure: 16 bits of 3C5B, random ready, mem inverted mid-transfer
        bp_data    = 16'h3C5B;
        captured   = 16'h0000;
        nbits      = 0;
        stall_prev = 1'b0;
        dout_prev  = 1'b0;
        sl_prev    = 4'd0;
        seen_done  = 1'b0;
        dout_ready = 1'b0;
        start_transfer(4'd0, 4'd0, bp_data);
        for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
            if (stall_prev) begin
                check_value("t4_stall_dout", {31'd0, w_dout}, {31'd0, dout_prev});
                check_value("t4_stall_sl",   {28'd0, w_sl},   {28'd0, sl_prev});
            end
            if (w_done) seen_done = 1'b1;
            ready_new  = (cyc < 2) ? 1'b0 : 1'($urandom_range(1, 0));
            dout_ready = ready_new;
            if (w_valid && ready_new && nbits < 16) begin
                captured[nbits] = w_dout;
                nbits++;
            end
            if (nbits == 4) mem = ~bp_data;
            stall_prev = w_valid && !ready_new;
            dout_prev  = w_dout;
            sl_prev    = w_sl;
            if (!seen_done) @(negedge clk);
        end
        check_value("t4_done_seen", {31'd0, seen_done},  32'd1);
        check_value("t4_bits",      {16'd0, captured},   {16'd0, bp_data});
        check_value("t4_parity",    {31'd0, w_parity},   32'd1);
        check_value("t4_sent",      {27'd0, w_sent},     32'd16);
        dout_ready = 1'b1;
        wait_idle();

        // Reset on the 3rd bit; start held during reset is ignored
        start_transfer(4'd0, 4'd8, 16'hFFFF);
        repeat (3) @(negedge clk);
        check_value("t5_sent_pre", {27'd0, w_sent}, 32'd2);
        rst   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        check_value("t5_busy",  {31'd0, w_busy},  32'd0);
        check_value("t5_valid", {31'd0, w_valid}, 32'd0);
        check_value("t5_sent",  {27'd0, w_sent},  32'd0);
        check_value("t5_done",  {31'd0, w_done},  32'd0);
        check_value("t5_sl",    {28'd0, w_sl},    32'd0);
        @(negedge clk);
        check_value("t5_start_in_rst", {31'd0, w_busy}, 32'd0);
        start = 1'b0;
        rst   = 1'b1;
        @(negedge clk);
        check_value("t5_no_done", {30'd0, w_done, n_done}, 32'd0);

        // Start while busy is not queued: 00F0 from cell 4, pulse start mid-SEND
        start_transfer(4'd4, 4'd4, 16'h00F0);
        @(negedge clk);
        start_addr = 4'd0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_value("t6_sl",   {28'd0, w_sl},   32'd5);
        check_value("t6_dout", {31'd0, w_dout}, 32'd1);
        for (int i = 0; i < 20 && !w_done; i++) @(negedge clk);
        check_value("t6_done",   {31'd0, w_done},   32'd1);
        check_value("t6_sent",   {27'd0, w_sent},   32'd4);
        check_value("t6_parity", {31'd0, w_parity}, 32'd0);
        repeat (3) @(negedge clk);
        check_value("t6_no_queue", {30'd0, w_busy, n_busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
